// File: rtl/register_file.sv
// Architectural integer register file: two combinational read ports with write-through,
// one write port, a registered bypass copy of the last write, and a sequential soft-clear engine.
module register_file #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [REG_WIDTH-1:0] rs1_data,
  output logic [REG_WIDTH-1:0] rs2_data,
  input  logic                 rd_we,
  input  logic [4:0]           rd_addr,
  input  logic [REG_WIDTH-1:0] rd_data,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_addr,
  output logic [REG_WIDTH-1:0] fwd_data,
  input  logic                 clr_req,
  output logic                 busy
);

  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      clr_idx_q, clr_idx_d;
  logic [REG_WIDTH-1:0]   regs_q [REG_COUNT];
  logic [REG_WIDTH-1:0]   regs_d [REG_COUNT];
  logic                   fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0]      fwd_addr_q, fwd_addr_d;
  logic [REG_WIDTH-1:0]   fwd_data_q, fwd_data_d;
  logic                   busy_q, busy_d;
  logic                   accepted_c;

  assign accepted_c = rd_we && (state_q == IDLE) && (rd_addr != '0);

  // Reads see an accepted same-cycle write before it lands in storage; x0 is hardwired to zero.
  assign rs1_data = (rs1_addr == '0) ? '0 :
                    (accepted_c && (rd_addr == rs1_addr)) ? rd_data : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 :
                    (accepted_c && (rd_addr == rs2_addr)) ? rd_data : regs_q[rs2_addr];

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    regs_d      = regs_q;
    fwd_valid_d = accepted_c;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;

    if (accepted_c) begin
      fwd_addr_d = rd_addr;
      fwd_data_d = rd_data;
    end

    case (state_q)
      IDLE: begin
        // A write accepted alongside clr_req still lands; the sweep zeroes it later.
        if (accepted_c) regs_d[rd_addr] = rd_data;
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = ADDR_W'(1);
        end
      end
      CLEAR: begin
        regs_d[clr_idx_q] = '0;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          clr_idx_d = ADDR_W'(1);
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_idx_q   <= ADDR_W'(1);
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < int'(REG_COUNT); i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      busy_q      <= busy_d;
      regs_q      <= regs_d;
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_addr  = fwd_addr_q;
  assign fwd_data  = fwd_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table for read/write/forwarding, plus
// hand-written sequences for the clear engine and mid-clear reset.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, fwd_addr;
  logic [31:0] rs1_data, rs2_data, rd_data, fwd_data;
  logic        rd_we, fwd_valid, clr_req, busy;

  int n_vec;
  int n_err;

  register_file #(.REG_WIDTH(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .clr_req(clr_req), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        efv;
    logic [4:0]  efa;
    logic [31:0] efd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_we = 1'b0; rd_addr = '0; rd_data = '0; clr_req = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rd_we = 1'b1; rd_addr = a; rd_data = d;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    rs1_addr = a;
    #1 check(name, rs1_data, exp);
  endtask

  vec_t vt [8];
  int   cyc;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; rs1_addr = '0; rs2_addr = '0;
    idle_inputs();

    // Table: write/read per row; reads checked before the edge, forward regs after it.
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF};
    vt[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5'd5,  32'hDEADBEEF};
    vt[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b1, 5'd7,  32'h12345678};
    vt[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h12345678, 1'b0, 5'd7,  32'h12345678};
    vt[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 5'd7,  32'h12345678};
    vt[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 1'b1, 5'd31, 32'hA5A5A5A5};
    vt[6] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd31, 32'h00000001, 32'hA5A5A5A5, 1'b1, 5'd5,  32'h00000001};
    vt[7] = '{1'b0, 5'd5,  32'h0000FFFF, 5'd5,  5'd0,  32'h00000001, 32'h0,        1'b0, 5'd5,  32'h00000001};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'h0);
    check("rst_fwd_addr", 32'(fwd_addr), 32'h0);
    check("rst_fwd_data", fwd_data, 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_we = vt[i].we; rd_addr = vt[i].wa; rd_data = vt[i].wd;
      rs1_addr = vt[i].r1; rs2_addr = vt[i].r2;
      #1;
      check($sformatf("v%0d_rs1", i), rs1_data, vt[i].e1);
      check($sformatf("v%0d_rs2", i), rs2_data, vt[i].e2);
      @(posedge clk); #1;
      check($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid), 32'(vt[i].efv));
      check($sformatf("v%0d_fwd_addr", i), 32'(fwd_addr), 32'(vt[i].efa));
      check($sformatf("v%0d_fwd_data", i), fwd_data, vt[i].efd);
    end
    idle_inputs();

    // Fill x1..x31 with their index, then run a full clear with a write dropped mid-sweep.
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
    read_check("fill_x17", 5'd17, 32'd17);
    @(negedge clk); clr_req = 1'b1;
    @(posedge clk); #1; clr_req = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
      if (cyc == 20) begin
        rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'hAA;
        rs1_addr = 5'd3; rs2_addr = 5'd25;
        #1;
        check("clr_wt_x3", rs1_data, 32'h0);
        check("clr_pending_x25", rs2_data, 32'd25);
      end
      @(posedge clk); #1;
      if (cyc == 20) begin
        check("clr_fwd_valid", 32'(fwd_valid), 32'h0);
        idle_inputs();
      end
    end
    check("clr_busy_cycles", 32'(cyc), 32'd31);
    for (int i = 1; i < 32; i++) read_check($sformatf("cleared_x%0d", i), 5'(i), 32'h0);

    // clr_req and a write in the same IDLE cycle: write lands, then gets swept.
    @(negedge clk);
    rd_we = 1'b1; rd_addr = 5'd9; rd_data = 32'h55; clr_req = 1'b1; rs1_addr = 5'd9;
    #1 check("x9_wt", rs1_data, 32'h55);
    @(posedge clk); #1;
    idle_inputs();
    check("x9_busy", 32'(busy), 32'h1);
    check("x9_fwd_valid", 32'(fwd_valid), 32'h1);
    read_check("x9_stored", 5'd9, 32'h55);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    check("x9_busy_fell", 32'(busy), 32'h0);
    read_check("x9_cleared", 5'd9, 32'h0);

    // Reset in the middle of a clear.
    write_reg(5'd30, 32'h30);
    write_reg(5'd2, 32'h77);
    @(negedge clk); clr_req = 1'b1;
    @(posedge clk); #1; clr_req = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 1'b1; rs1_addr = 5'd30; rs2_addr = 5'd2;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_x30", rs1_data, 32'h0);
    check("mid_rst_x2", rs2_data, 32'h0);
    check("mid_rst_fwd_addr", 32'(fwd_addr), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(busy), 32'h0);
    write_reg(5'd2, 32'h1);
    check("post_rst_fwd_valid", 32'(fwd_valid), 32'h1);
    read_check("post_rst_x2", 5'd2, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
